// File: rtl/core_timer_irq_service_if.sv
// Avalon-MM write port and level interrupt between the service block and the interval timer.
// The master side drives the bus and consumes timer_irq; the slave side is the timer.
interface core_timer_irq_service_if;
  logic        timer_irq;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;

  modport master (
    input  timer_irq,
    output tmr_address,
    output tmr_chipselect,
    output tmr_write_n,
    output tmr_writedata
  );

  modport slave (
    output timer_irq,
    input  tmr_address,
    input  tmr_chipselect,
    input  tmr_write_n,
    input  tmr_writedata
  );
endinterface

// File: rtl/core_timer_irq_service.sv
// Starts the interval timer, then acks each interrupt and fans it out as divided per-channel ticks.
// Bus write lands 1 cycle after IDLE sees timer_irq; ticks/tick_count land 2 cycles after; no backpressure.
module core_timer_irq_service #(
  parameter int          NUM_CH    = 4,
  parameter int          DIV_W     = 8,
  parameter logic [15:0] INIT_CTRL = 16'h0007
) (
  input  logic                      clk,
  input  logic                      reset,
  core_timer_irq_service_if.master  tmr,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH*DIV_W-1:0]   ch_divisor,
  output logic [NUM_CH-1:0]         ch_tick,
  output logic [31:0]               tick_count,
  output logic                      busy
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACK,
    ST_DISPATCH
  } state_e;

  localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

  state_e                         state_q, state_d;
  logic                           cs_q, cs_d;
  logic                           write_n_q, write_n_d;
  logic [2:0]                     addr_q, addr_d;
  logic [15:0]                    wdata_q, wdata_d;
  logic [NUM_CH-1:0]              tick_q, tick_d;
  logic [31:0]                    tick_count_q, tick_count_d;
  logic                           busy_q, busy_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   ch_cnt_q, ch_cnt_d;

  always_comb begin
    state_d      = state_q;
    cs_d         = 1'b0;
    write_n_d    = 1'b1;
    addr_d       = 3'd0;
    wdata_d      = 16'd0;
    tick_d       = '0;
    tick_count_d = tick_count_q;
    ch_cnt_d     = ch_cnt_q;

    case (state_q)
      ST_INIT: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = 3'd1;
        wdata_d   = INIT_CTRL;
        state_d   = ST_IDLE;
      end
      ST_IDLE: begin
        // Status write (address 0, data 0) is launched here so it is on the bus during ACK.
        if (tmr.timer_irq) begin
          cs_d      = 1'b1;
          write_n_d = 1'b0;
          state_d   = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_DISPATCH;
      end
      ST_DISPATCH: begin
        tick_count_d = tick_count_q + 32'd1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!ch_enable[i]) begin
            ch_cnt_d[i] = '0;
          end else if (ch_cnt_q[i] == '0) begin
            tick_d[i]   = 1'b1;
            ch_cnt_d[i] = ch_divisor[i*DIV_W +: DIV_W];
          end else begin
            ch_cnt_d[i] = ch_cnt_q[i] - CNT_ONE;
          end
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      cs_q         <= 1'b0;
      write_n_q    <= 1'b1;
      addr_q       <= 3'd0;
      wdata_q      <= 16'd0;
      tick_q       <= '0;
      tick_count_q <= 32'd0;
      busy_q       <= 1'b1;
      ch_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cs_q         <= cs_d;
      write_n_q    <= write_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      busy_q       <= busy_d;
      ch_cnt_q     <= ch_cnt_d;
    end
  end

  assign tmr.tmr_chipselect = cs_q;
  assign tmr.tmr_write_n    = write_n_q;
  assign tmr.tmr_address    = addr_q;
  assign tmr.tmr_writedata  = wdata_q;
  assign ch_tick            = tick_q;
  assign tick_count         = tick_count_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_core_timer_irq_service.sv
// Bench for core_timer_irq_service: models the timer's level interrupt and scoreboards bus writes and dispatches.
module tb_core_timer_irq_service;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_enable;
  logic [31:0] ch_divisor;
  logic [3:0]  ch_tick;
  logic [31:0] tick_count;
  logic        busy;

  always #5 clk = ~clk;

  core_timer_irq_service_if tmr ();

  core_timer_irq_service dut (
    .clk        (clk),
    .reset      (reset),
    .tmr        (tmr),
    .ch_enable  (ch_enable),
    .ch_divisor (ch_divisor),
    .ch_tick    (ch_tick),
    .tick_count (tick_count),
    .busy       (busy)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  bit          prev_busy = 1'b0;
  logic [18:0] wr_q[$];
  logic [35:0] ev_q[$];
  logic [3:0]  obs_q[$];
  logic [7:0]  m_cnt[4];
  logic [31:0] m_count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, compare against the scoreboard, model the timer's irq clear.
  task automatic step();
    logic [18:0] wexp;
    logic [35:0] eexp;
    @(negedge clk);
    if (tmr.tmr_chipselect) begin
      chk("wr_strobe", 64'(tmr.tmr_write_n), 64'd0);
      chk("wr_expected", 64'(wr_q.size() > 0), 64'd1);
      if (wr_q.size() > 0) begin
        wexp = wr_q.pop_front();
        chk("wr_addr_data", 64'({tmr.tmr_address, tmr.tmr_writedata}), 64'(wexp));
      end
      if (tmr.tmr_address == 3'd0) tmr.timer_irq = 1'b0;
    end else begin
      chk("bus_idle", 64'({tmr.tmr_write_n, tmr.tmr_address, tmr.tmr_writedata}),
          64'({1'b1, 3'd0, 16'd0}));
    end
    if (prev_busy && !busy && !(tmr.tmr_chipselect && tmr.tmr_address == 3'd1)) begin
      chk("ev_expected", 64'(ev_q.size() > 0), 64'd1);
      if (ev_q.size() > 0) begin
        eexp = ev_q.pop_front();
        chk("dispatch", 64'({ch_tick, tick_count}), 64'(eexp));
      end
      obs_q.push_back(ch_tick);
    end else begin
      chk("no_stray_tick", 64'(ch_tick), 64'd0);
    end
    prev_busy = busy;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 8'd0;
    m_count = 32'd0;
  endtask

  task automatic model_event();
    logic [3:0] t;
    t = 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (!ch_enable[i]) begin
        m_cnt[i] = 8'd0;
      end else if (m_cnt[i] == 8'd0) begin
        t[i]     = 1'b1;
        m_cnt[i] = ch_divisor[i*8 +: 8];
      end else begin
        m_cnt[i] = m_cnt[i] - 8'd1;
      end
    end
    m_count = m_count + 32'd1;
    wr_q.push_back({3'd0, 16'd0});
    ev_q.push_back({t, m_count});
  endtask

  task automatic wait_ack();
    for (int k = 0; k < 10 && tmr.timer_irq; k++) step();
    chk("ack_seen", 64'(tmr.timer_irq), 64'd0);
  endtask

  task automatic fire();
    model_event();
    tmr.timer_irq = 1'b1;
    wait_ack();
    repeat (3) step();
  endtask

  initial begin
    logic [8:0] pat1;
    logic [3:0] pat2;
    int         base;
    tmr.timer_irq = 1'b0;
    ch_enable     = 4'd0;
    ch_divisor    = 32'd0;
    model_reset();

    // Reset state
    repeat (3) step();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_cs", 64'(tmr.tmr_chipselect), 64'd0);
    chk("rst_tick_count", 64'(tick_count), 64'd0);
    chk("rst_ch_tick", 64'(ch_tick), 64'd0);

    // Single INIT write right after release, then idle
    wr_q.push_back({3'd1, 16'h0007});
    reset = 1'b0;
    step();
    chk("init_cs", 64'(tmr.tmr_chipselect), 64'd1);
    chk("init_busy", 64'(busy), 64'd0);
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("init_once", 64'(wr_q.size()), 64'd0);

    // First event, channel 0 divisor 0
    ch_enable = 4'b0001;
    fire();
    chk("first_count", 64'(tick_count), 64'd1);

    // Channel 1 divisor 2 over 9 events
    ch_divisor[15:8] = 8'd2;
    ch_enable        = 4'b0011;
    base = obs_q.size();
    repeat (9) fire();
    pat1 = 9'd0;
    for (int k = 0; k < 9; k++) pat1[k] = obs_q[base + k][1];
    chk("ch1_pattern", 64'(pat1), 64'(9'b001001001));
    chk("ch1_count", 64'(tick_count), 64'd10);

    // Wrap of tick_count from all-ones
    step();
    force dut.tick_count_q = 32'hFFFF_FFFF;
    step();
    step();
    release dut.tick_count_q;
    m_count = 32'hFFFF_FFFF;
    step();
    chk("preload", 64'(tick_count), 64'hFFFF_FFFF);
    fire();
    chk("wrap", 64'(tick_count), 64'd0);

    // Channel 2: re-enable ticks immediately; divisor change takes effect at reload
    ch_divisor[23:16] = 8'd3;
    ch_enable         = 4'b0111;
    base = obs_q.size();
    fire();
    fire();
    ch_enable[2] = 1'b0;
    fire();
    ch_enable[2] = 1'b1;
    fire();
    pat2 = 4'd0;
    for (int k = 0; k < 4; k++) pat2[k] = obs_q[base + k][2];
    chk("ch2_reenable", 64'(pat2), 64'(4'b1001));
    ch_divisor[23:16] = 8'd0;
    repeat (4) fire();

    // Reset during the ACK cycle, with the interrupt still pending through INIT
    chk("pre_rst_count", 64'(tick_count), 64'd8);
    wr_q.push_back({3'd0, 16'd0});
    tmr.timer_irq = 1'b1;
    wait_ack();
    reset = 1'b1;
    step();
    chk("abort_cs", 64'(tmr.tmr_chipselect), 64'd0);
    chk("abort_busy", 64'(busy), 64'd1);
    chk("abort_count", 64'(tick_count), 64'd0);
    model_reset();
    tmr.timer_irq = 1'b1;
    wr_q.push_back({3'd1, 16'h0007});
    model_event();
    step();
    reset = 1'b0;
    wait_ack();
    repeat (3) step();
    chk("after_rst_count", 64'(tick_count), 64'd1);

    chk("wr_left", 64'(wr_q.size()), 64'd0);
    chk("ev_left", 64'(ev_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
